// File: rtl/mips16_dbg_tx_if.sv
// Byte stream from the debug-snapshot transmitter to its reader.
// The master drives tx_data/tx_valid. The slave drives tx_ready.
// A byte transfers on each rising clock edge where tx_valid && tx_ready.
interface mips16_dbg_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/mips16_dbg_tx.sv
// mips16_dbg_tx: captures the mips16 PC and register file when a request
// arrives, then sends the snapshot as a byte frame over a valid/ready stream.
//
// Frame layout:
//   HDR, seq, pc[15:8], pc[7:0], then for each register: hi byte, lo byte.
//
// Optional feature: define DBG_TX_CKSUM_EN to append one trailing byte.
// That byte is chosen so that the mod-256 sum of every frame byte is zero.
module mips16_dbg_tx #(
  parameter int          NREGS  = 8,
  parameter int          DATA_W = 16,
  parameter int          PC_W   = 13,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    snap_req,
  input  logic [PC_W-1:0]         pc_in,
  input  logic [NREGS*DATA_W-1:0] regs_in,
  mips16_dbg_tx_if.master         tx,
  output logic                    busy,
  output logic                    overrun,
  output logic [7:0]              seq
);

  localparam int FRAME_LEN = 4 + 2 * NREGS;
  localparam int RW        = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1
`ifdef DBG_TX_CKSUM_EN
    ,
    CKSUM = 2'd2
`endif
  } state_t;

  state_t            state, state_nx;
  logic [4:0]        idx;
  logic [15:0]       pc_q;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [7:0]        seq_q;
  logic              overrun_q;
  logic [7:0]        byte_sel;
  logic [RW-1:0]     reg_sel;
  logic [DATA_W-1:0] cur_reg;
  logic              hs;
  logic              last_byte;
  logic              start;
  logic              frame_done;
`ifdef DBG_TX_CKSUM_EN
  logic [7:0]        sum_q;
`endif

  assign hs        = tx.tx_valid && tx.tx_ready;
  assign last_byte = (idx == 5'(FRAME_LEN - 1));
  assign start     = (state == IDLE) && snap_req;

  // State register.
  // NOTE: sequential state is written only with non-blocking (<=).
  // That way every flop samples the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and end-of-frame detection.
  // NOTE: every output of this block is given a default first.
  // Without those defaults, a path that skips an assignment would infer a latch.
  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    case (state)
      IDLE: if (snap_req) state_nx = SEND;
      SEND: begin
        if (hs && last_byte) begin
`ifdef DBG_TX_CKSUM_EN
          state_nx   = CKSUM;
`else
          state_nx   = IDLE;
          frame_done = 1'b1;
`endif
        end
      end
`ifdef DBG_TX_CKSUM_EN
      CKSUM: begin
        if (hs) begin
          state_nx   = IDLE;
          frame_done = 1'b1;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Snapshot capture, byte index, sequence number and the sticky overrun flag.
  // NOTE: the snapshot registers are cleared on reset.
  // This keeps the transmit path free of X values right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= 5'd0;
      pc_q      <= 16'd0;
      seq_q     <= 8'd0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else begin
      if (start) begin
        idx  <= 5'd0;
        pc_q <= 16'(pc_in);
        for (int k = 0; k < NREGS; k++) regs_q[k] <= regs_in[k*DATA_W +: DATA_W];
      end else if (hs && state == SEND) begin
        idx <= idx + 5'd1;
      end
      if (frame_done)                  seq_q     <= seq_q + 8'd1;
      if (snap_req && state != IDLE)   overrun_q <= 1'b1;
    end
  end

`ifdef DBG_TX_CKSUM_EN
  // Running sum of the bytes already sent. Its negation is the checksum byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         sum_q <= 8'd0;
    else if (start)                  sum_q <= 8'd0;
    else if (hs && state == SEND)    sum_q <= sum_q + byte_sel;
  end
`endif

  // Select the frame byte addressed by idx.
  // Registers start at idx 4, two bytes per register, high byte first.
  always_comb begin
    reg_sel  = RW'((idx - 5'd4) >> 1);
    cur_reg  = regs_q[reg_sel];
    byte_sel = 8'd0;
    case (idx)
      5'd0:    byte_sel = HDR;
      5'd1:    byte_sel = seq_q;
      5'd2:    byte_sel = pc_q[15:8];
      5'd3:    byte_sel = pc_q[7:0];
      default: byte_sel = idx[0] ? cur_reg[7:0] : cur_reg[15:8];
    endcase
  end

  // Stream outputs.
  // tx_data depends only on registered state, so it holds steady while the reader stalls.
  always_comb begin
    tx.tx_valid = (state != IDLE);
    tx.tx_data  = 8'd0;
    if (state == SEND) tx.tx_data = byte_sel;
`ifdef DBG_TX_CKSUM_EN
    if (state == CKSUM) tx.tx_data = ~sum_q + 8'd1;
`endif
  end

  assign busy    = (state != IDLE);
  assign overrun = overrun_q;
  assign seq     = seq_q;

endmodule

// File: tb/tb_mips16_dbg_tx.sv
// Directed bench for mips16_dbg_tx (NREGS=8, PC_W=13).
module tb_mips16_dbg_tx;

`ifdef DBG_TX_CKSUM_EN
  localparam int FLEN = 21;
`else
  localparam int FLEN = 20;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         snap_req = 1'b0;
  logic [12:0]  pc_in = '0;
  logic [127:0] regs_in = '0;
  logic         busy, overrun;
  logic [7:0]   seq;

  mips16_dbg_tx_if tx();

  mips16_dbg_tx dut (
    .clk      (clk),
    .rst      (rst),
    .snap_req (snap_req),
    .pc_in    (pc_in),
    .regs_in  (regs_in),
    .tx       (tx),
    .busy     (busy),
    .overrun  (overrun),
    .seq      (seq)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_b [0:31];
  logic [7:0] got   [0:31];
  int         ncyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected frame bytes computed from the snapshot contents.
  task automatic build(input logic [7:0] s, input logic [12:0] pc, input logic [127:0] r);
    int sum;
    exp_b[0] = 8'hA5;
    exp_b[1] = s;
    exp_b[2] = {3'b000, pc[12:8]};
    exp_b[3] = pc[7:0];
    for (int k = 0; k < 8; k++) begin
      exp_b[4 + 2*k] = r[16*k + 8 +: 8];
      exp_b[5 + 2*k] = r[16*k +: 8];
    end
    sum = 0;
    for (int i = 0; i < 20; i++) sum += int'(exp_b[i]);
    exp_b[20] = 8'((256 - (sum % 256)) % 256);
  endtask

  // Pulse snap_req for one cycle, then check that tx_valid rises on the next cycle.
  task automatic pulse();
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    check("lat_valid", 32'(tx.tx_valid), 1);
    check("lat_busy", 32'(busy), 1);
  endtask

  // Receive bytes until stop_at of them have been accepted.
  // Called at a negedge, with the frame already valid.
  task automatic recv(input int stop_at, input bit toggle, input bit scramble,
                      input int req_a, input int req_b);
    int k = 0;
    int cyc = 0;
    bit ph = 1'b1;
    bit rdy;
    bit was_held = 1'b0;
    logic [7:0] held = '0;
    while (k < stop_at && cyc < 200) begin
      if (was_held) check("hold_data", 32'(tx.tx_data), 32'(held));
      check("valid_in_frame", 32'(tx.tx_valid), 1);
      rdy = toggle ? ph : 1'b1;
      ph = ~ph;
      tx.tx_ready = rdy;
      snap_req = (k == req_a || k == req_b);
      if (tx.tx_valid && rdy) begin
        check($sformatf("byte%0d", k), 32'(tx.tx_data), 32'(exp_b[k]));
        got[k] = tx.tx_data;
        k++;
        was_held = 1'b0;
      end else begin
        held = tx.tx_data;
        was_held = 1'b1;
      end
      if (scramble && k == 6) begin
        pc_in   = 13'h1FFF;
        regs_in = {4{32'hDEAD_BEEF}};
      end
      @(negedge clk);
      cyc++;
    end
    snap_req = 1'b0;
    tx.tx_ready = 1'b1;
    ncyc = cyc;
    if (k < stop_at) check("recv_timeout", 32'(k), 32'(stop_at));
  endtask

  task automatic post_frame(input logic [7:0] s);
    check("post_valid", 32'(tx.tx_valid), 0);
    check("post_busy", 32'(busy), 0);
    check("post_seq", 32'(seq), 32'(s));
  endtask

  logic [127:0] r_base;
  logic [7:0]   s_exp;
  int           sum;

  initial begin
    tx.tx_ready = 1'b0;
    for (int k = 0; k < 8; k++) r_base[16*k +: 16] = 16'(k + 1);

    // 1: reset state and quiet idle.
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(tx.tx_valid), 0);
    check("rst_data", 32'(tx.tx_data), 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_state", {22'd0, tx.tx_valid, busy, seq}, 0);
      check("idle_overrun", 32'(overrun), 0);
    end

    // 2: basic frame with tx_ready held at 1.
    pc_in = 13'h0123;
    regs_in = r_base;
    build(8'd0, pc_in, regs_in);
    pulse();
    recv(FLEN, 1'b0, 1'b0, -1, -1);
    check("t2_cycles", 32'(ncyc), 32'(FLEN));
    check("t2_hdr", 32'(got[0]), 32'h A5);
    check("t2_pchi", 32'(got[2]), 32'h01);
    check("t2_pclo", 32'(got[3]), 32'h23);
    check("t2_r7lo", 32'(got[19]), 32'h08);
    post_frame(8'd1);
`ifdef DBG_TX_CKSUM_EN
    sum = 0;
    for (int i = 0; i < 21; i++) sum += int'(got[i]);
    check("t6_cksum_sum", 32'(sum % 256), 0);
`endif

    // 3: tx_ready toggling, inputs changed mid-frame.
    pc_in = 13'h0123;
    regs_in = r_base;
    build(8'd1, pc_in, regs_in);
    pulse();
    recv(FLEN, 1'b1, 1'b1, -1, -1);
    post_frame(8'd2);

    // 4: requests while busy are dropped and set overrun.
    check("t4_overrun_pre", 32'(overrun), 0);
    pc_in = 13'h1ABC;
    regs_in = {8{16'h5AC3}};
    build(8'd2, pc_in, regs_in);
    pulse();
    recv(FLEN, 1'b0, 1'b0, 5, FLEN - 1);
    post_frame(8'd3);
    check("t4_overrun", 32'(overrun), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_no_frame", 32'(tx.tx_valid), 0);
    end

    // 5: reset in the middle of a frame.
    build(8'd3, pc_in, regs_in);
    pulse();
    recv(7, 1'b0, 1'b0, -1, -1);
    rst = 1'b1;
    #1;
    check("t5_valid", 32'(tx.tx_valid), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_seq", 32'(seq), 0);
    check("t5_overrun", 32'(overrun), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pc_in = 13'h0123;
    regs_in = r_base;
    build(8'd0, pc_in, regs_in);
    pulse();
    recv(FLEN, 1'b0, 1'b0, -1, -1);
    check("t5_seqbyte", 32'(got[1]), 0);
    post_frame(8'd1);

    // 6: 256 frames; the sequence number wraps from 255 to 0.
    s_exp = 8'd1;
    for (int f = 0; f < 256; f++) begin
      build(s_exp, pc_in, regs_in);
      pulse();
      recv(FLEN, 1'b0, 1'b0, -1, -1);
      s_exp = s_exp + 8'd1;
      check("wrap_seq", 32'(seq), 32'(s_exp));
      @(negedge clk);
    end
    check("wrap_final", 32'(seq), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
